sign_corr_bank: RTL and testbench



---
 rtl/sign_corr_bank_if.sv | 26 ++
 rtl/sign_corr_bank.sv | 113 +++++++++++
 tb/tb_sign_corr_bank.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sign_corr_bank_if.sv
// Request/result bundle for sign_corr_bank: sample-in controls and the Un vector out.
interface sign_corr_bank_if #(
  parameter int NTAPS = 6,
  parameter int DQ_W  = 16,
  parameter int DQN_W = 11
);
  logic              start;
  logic              init;
  logic              zero_gate;
  logic [DQ_W-1:0]   DQ;
  logic [DQN_W-1:0]  DQn_in;
  logic              busy;
  logic              done;
  logic              dq_zero;
  logic [NTAPS-1:0]  un_vec;

  modport master (
    output start, init, zero_gate, DQ, DQn_in,
    input  busy, done, dq_zero, un_vec
  );

  modport slave (
    input  start, init, zero_gate, DQ, DQn_in,
    output busy, done, dq_zero, un_vec
  );
endinterface

// File: rtl/sign_corr_bank.sv
// Serial sign-correlation of DQ against an NTAPS-deep history, one tap per clock.
// Latency NTAPS+2 cycles from accepted start to done; start/init are ignored while busy.
module sign_corr_bank #(
  parameter int NTAPS = 6,
  parameter int DQ_W  = 16,
  parameter int DQN_W = 11
) (
  input  logic clk,
  input  logic reset,
  input  logic scan_in0,
  input  logic scan_in1,
  input  logic scan_in2,
  input  logic scan_in3,
  input  logic scan_in4,
  input  logic scan_enable,
  input  logic test_mode,
  output logic scan_out0,
  output logic scan_out1,
  output logic scan_out2,
  output logic scan_out3,
  output logic scan_out4,
  sign_corr_bank_if.slave bus
);
  localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [DQN_W-1:0] HIST_INIT = DQN_W'(11'h020);

  typedef enum logic [1:0] {IDLE, EVAL, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [KW-1:0]      k;
  logic               sgn_q;
  logic               mag_zero;
  logic               gate_q;
  logic [DQN_W-1:0]   dqn_q;
  logic [NTAPS-1:0]   work;
  logic [DQN_W-1:0]   hist [NTAPS];
  logic               accept;
  logic               reload;

  logic unused_dft;
  assign unused_dft = &{1'b0, scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                        scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  // init wins over a coincident start; that start is simply lost
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reload    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.init) begin
          reload = 1'b1;
        end else if (bus.start) begin
          accept    = 1'b1;
          state_nxt = EVAL;
        end
      end
      EVAL:    if (k == KW'(NTAPS - 1)) state_nxt = SHIFT;
      SHIFT:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k           <= '0;
      sgn_q       <= 1'b0;
      mag_zero    <= 1'b0;
      gate_q      <= 1'b0;
      dqn_q       <= '0;
      work        <= '0;
      bus.un_vec  <= '0;
      bus.dq_zero <= 1'b0;
      for (int i = 0; i < NTAPS; i++) hist[i] <= HIST_INIT;
    end else begin
      if (accept) begin
        sgn_q    <= bus.DQ[DQ_W-1];
        mag_zero <= (bus.DQ[DQ_W-2:0] == '0);
        gate_q   <= bus.zero_gate & (bus.DQ[DQ_W-2:0] == '0);
        dqn_q    <= bus.DQn_in;
        k        <= '0;
      end
      if (reload) begin
        for (int i = 0; i < NTAPS; i++) hist[i] <= HIST_INIT;
      end
      if (state == EVAL) begin
        work[k] <= gate_q ? 1'b0 : (sgn_q ^ hist[k][DQN_W-1]);
        k       <= k + 1'b1;
      end
      // work is complete once SHIFT is reached; publish on entry to DONE
      if (state == SHIFT) begin
        hist[0] <= dqn_q;
        for (int j = 1; j < NTAPS; j++) hist[j] <= hist[j-1];
        bus.un_vec  <= work;
        bus.dq_zero <= mag_zero;
      end
    end
  end
endmodule

// File: tb/tb_sign_corr_bank.sv
// Directed checks on an NTAPS=6 build plus random model comparison on NTAPS=1 and NTAPS=8 builds.
module tb_sign_corr_bank;
  logic clk = 1'b0;
  logic reset;
  logic dft_in = 1'b0;
  logic [4:0] so6, so1, so8;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sign_corr_bank_if #(.NTAPS(6), .DQ_W(16), .DQN_W(11)) i6 ();
  sign_corr_bank_if #(.NTAPS(1), .DQ_W(16), .DQN_W(11)) ia1 ();
  sign_corr_bank_if #(.NTAPS(8), .DQ_W(16), .DQN_W(11)) ia8 ();

  sign_corr_bank #(.NTAPS(6), .DQ_W(16), .DQN_W(11)) dut6 (
    .clk(clk), .reset(reset),
    .scan_in0(dft_in), .scan_in1(dft_in), .scan_in2(dft_in), .scan_in3(dft_in), .scan_in4(dft_in),
    .scan_enable(dft_in), .test_mode(dft_in),
    .scan_out0(so6[0]), .scan_out1(so6[1]), .scan_out2(so6[2]), .scan_out3(so6[3]), .scan_out4(so6[4]),
    .bus(i6)
  );

  sign_corr_bank #(.NTAPS(1), .DQ_W(16), .DQN_W(11)) dut1 (
    .clk(clk), .reset(reset),
    .scan_in0(dft_in), .scan_in1(dft_in), .scan_in2(dft_in), .scan_in3(dft_in), .scan_in4(dft_in),
    .scan_enable(dft_in), .test_mode(dft_in),
    .scan_out0(so1[0]), .scan_out1(so1[1]), .scan_out2(so1[2]), .scan_out3(so1[3]), .scan_out4(so1[4]),
    .bus(ia1)
  );

  sign_corr_bank #(.NTAPS(8), .DQ_W(16), .DQN_W(11)) dut8 (
    .clk(clk), .reset(reset),
    .scan_in0(dft_in), .scan_in1(dft_in), .scan_in2(dft_in), .scan_in3(dft_in), .scan_in4(dft_in),
    .scan_enable(dft_in), .test_mode(dft_in),
    .scan_out0(so8[0]), .scan_out1(so8[1]), .scan_out2(so8[2]), .scan_out3(so8[3]), .scan_out4(so8[4]),
    .bus(ia8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the NTAPS=6 unit; lat counts clock periods after the accepting edge.
  task automatic run6(input logic [15:0] dq, input logic [10:0] dqn, input logic zg,
                      output int lat, output logic busy1);
    @(negedge clk);
    i6.DQ = dq; i6.DQn_in = dqn; i6.zero_gate = zg; i6.start = 1'b1;
    @(negedge clk);
    i6.start = 1'b0;
    busy1 = i6.busy;
    lat = 1;
    while (!i6.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic b1;
    int nd;
    logic [5:0] cap;
    logic [15:0] dq;
    logic [10:0] dqn;
    logic zg, gate;
    logic [7:0] m8, e8, c8;
    logic m1, e1, c1, dz8;
    int l1, l8;

    reset = 1'b0;
    i6.start = 0;  i6.init = 0;  i6.zero_gate = 0;  i6.DQ = '0;  i6.DQn_in = '0;
    ia1.start = 0; ia1.init = 0; ia1.zero_gate = 0; ia1.DQ = '0; ia1.DQn_in = '0;
    ia8.start = 0; ia8.init = 0; ia8.zero_gate = 0; ia8.DQ = '0; ia8.DQn_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(i6.busy), 32'd0);
    chk("rst_done", 32'(i6.done), 32'd0);
    chk("rst_dq_zero", 32'(i6.dq_zero), 32'd0);
    chk("rst_un_vec", 32'(i6.un_vec), 32'd0);
    chk("scan_out", 32'(so6), 32'd0);
    reset = 1'b1;

    // negative DQ against all-positive reset history
    run6(16'h8005, 11'h4A3, 1'b0, lat, b1);
    chk("s1_busy_p1", 32'(b1), 32'd1);
    chk("s1_latency", 32'(lat), 32'd8);
    chk("s1_un_vec", 32'(i6.un_vec), 32'h3F);
    chk("s1_dq_zero", 32'(i6.dq_zero), 32'd0);
    @(negedge clk);
    chk("s1_done_pulse", 32'(i6.done), 32'd0);
    chk("s1_un_hold", 32'(i6.un_vec), 32'h3F);

    // only tap 0 (11'h4A3) is negative
    run6(16'h0003, 11'h010, 1'b0, lat, b1);
    chk("s2_latency", 32'(lat), 32'd8);
    chk("s2_un_vec", 32'(i6.un_vec), 32'h01);

    // gated negative zero
    run6(16'h8000, 11'h7FF, 1'b1, lat, b1);
    chk("s3_un_vec", 32'(i6.un_vec), 32'h00);
    chk("s3_dq_zero", 32'(i6.dq_zero), 32'd1);

    // ungated positive zero exposes history signs [1,0,1,0,0,0]
    run6(16'h0000, 11'h020, 1'b0, lat, b1);
    chk("s4_un_vec", 32'(i6.un_vec), 32'h05);
    chk("s4_dq_zero", 32'(i6.dq_zero), 32'd1);

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    i6.DQ = 16'h0001; i6.DQn_in = 11'h400; i6.zero_gate = 0; i6.start = 1'b1;
    @(negedge clk);
    i6.start = 1'b0;
    nd = 0; cap = '0;
    for (int p = 1; p <= 20; p++) begin
      if (i6.done) begin nd++; cap = i6.un_vec; end
      i6.start = (p == 3);
      if (p == 3) i6.DQ = 16'h8001;
      @(negedge clk);
    end
    chk("busy_start_ndone", 32'(nd), 32'd1);
    chk("busy_start_un_vec", 32'(cap), 32'h0A);

    // init together with start: reload only, no transaction
    i6.init = 1'b1; i6.start = 1'b1; i6.DQ = 16'h8001;
    @(negedge clk);
    i6.init = 1'b0; i6.start = 1'b0;
    nd = 0;
    for (int p = 1; p <= 12; p++) begin
      if (i6.done || i6.busy) nd++;
      @(negedge clk);
    end
    chk("init_start_activity", 32'(nd), 32'd0);
    run6(16'h8000, 11'h020, 1'b0, lat, b1);
    chk("init_un_vec", 32'(i6.un_vec), 32'h3F);
    chk("init_dq_zero", 32'(i6.dq_zero), 32'd1);

    // reset during EVAL abandons the sample without shifting
    @(negedge clk);
    i6.DQ = 16'h0001; i6.DQn_in = 11'h7FF; i6.start = 1'b1;
    @(negedge clk);
    i6.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(i6.busy), 32'd0);
    chk("mid_rst_done", 32'(i6.done), 32'd0);
    chk("mid_rst_un_vec", 32'(i6.un_vec), 32'd0);
    chk("mid_rst_dq_zero", 32'(i6.dq_zero), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run6(16'h0001, 11'h020, 1'b0, lat, b1);
    chk("post_rst_latency", 32'(lat), 32'd8);
    chk("post_rst_un_vec", 32'(i6.un_vec), 32'h00);

    // random samples on the NTAPS=1 and NTAPS=8 builds against a sign-history model
    m8 = '0; m1 = 1'b0;
    for (int s = 0; s < 1000; s++) begin
      dq  = 16'($urandom);
      if ($urandom_range(0, 3) == 0) dq[14:0] = '0;
      dqn = 11'($urandom);
      zg  = 1'($urandom_range(0, 1));
      gate = zg && (dq[14:0] == 15'd0);
      for (int t = 0; t < 8; t++) e8[t] = gate ? 1'b0 : (dq[15] ^ m8[t]);
      e1 = gate ? 1'b0 : (dq[15] ^ m1);
      ia1.DQ = dq; ia1.DQn_in = dqn; ia1.zero_gate = zg; ia1.start = 1'b1;
      ia8.DQ = dq; ia8.DQn_in = dqn; ia8.zero_gate = zg; ia8.start = 1'b1;
      @(negedge clk);
      ia1.start = 1'b0; ia8.start = 1'b0;
      l1 = 0; l8 = 0; c1 = 1'b0; c8 = '0; dz8 = 1'b0;
      for (int p = 1; p <= 16 && (l1 == 0 || l8 == 0); p++) begin
        if (ia1.done && l1 == 0) begin l1 = p; c1 = ia1.un_vec; end
        if (ia8.done && l8 == 0) begin l8 = p; c8 = ia8.un_vec; dz8 = ia8.dq_zero; end
        @(negedge clk);
      end
      chk("rnd_lat1", 32'(l1), 32'd3);
      chk("rnd_lat8", 32'(l8), 32'd10);
      chk("rnd_un1", 32'(c1), 32'(e1));
      chk("rnd_un8", 32'(c8), 32'(e8));
      chk("rnd_dq_zero8", 32'(dz8), 32'(dq[14:0] == 15'd0));
      m8 = {m8[6:0], dqn[10]};
      m1 = dqn[10];
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
